// File: rtl/dma_axi_mif.sv
// DMA AXI4 master interface: turns DMA read/write burst requests into AXI4
// AR/R and AW/W/B traffic, masks edge beats with byte strobes, moves data
// through an external FIFO and records the first bus error.
module dma_axi_mif #(
    parameter int unsigned AXI_ADDR_W = 32,
    parameter int unsigned AXI_DATA_W = 64,
    parameter int unsigned AXI_ID_W   = 4,
    parameter int unsigned RD_OUTS    = 4,
    parameter int unsigned WR_OUTS    = 4,
    parameter int unsigned DMA_ID     = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    // read request
    input  logic                    rd_req_valid,
    output logic                    rd_req_ready,
    input  logic [AXI_ADDR_W-1:0]   rd_req_addr,
    input  logic [7:0]              rd_req_len,
    input  logic [2:0]              rd_req_size,
    input  logic                    rd_req_incr,
    input  logic [AXI_DATA_W/8-1:0] rd_req_fstrb,
    input  logic [AXI_DATA_W/8-1:0] rd_req_lstrb,
    // write request
    input  logic                    wr_req_valid,
    output logic                    wr_req_ready,
    input  logic [AXI_ADDR_W-1:0]   wr_req_addr,
    input  logic [7:0]              wr_req_len,
    input  logic [2:0]              wr_req_size,
    input  logic                    wr_req_incr,
    input  logic [AXI_DATA_W/8-1:0] wr_req_fstrb,
    input  logic [AXI_DATA_W/8-1:0] wr_req_lstrb,
    // AXI AR
    output logic                    arvalid,
    input  logic                    arready,
    output logic [AXI_ADDR_W-1:0]   araddr,
    output logic [7:0]              arlen,
    output logic [2:0]              arsize,
    output logic [1:0]              arburst,
    output logic [AXI_ID_W-1:0]     arid,
    output logic [2:0]              arprot,
    // AXI R
    input  logic                    rvalid,
    input  logic [AXI_DATA_W-1:0]   rdata,
    input  logic [1:0]              rresp,
    input  logic                    rlast,
    output logic                    rready,
    // AXI AW
    output logic                    awvalid,
    input  logic                    awready,
    output logic [AXI_ADDR_W-1:0]   awaddr,
    output logic [7:0]              awlen,
    output logic [2:0]              awsize,
    output logic [1:0]              awburst,
    output logic [AXI_ID_W-1:0]     awid,
    output logic [2:0]              awprot,
    // AXI W
    output logic                    wvalid,
    input  logic                    wready,
    output logic [AXI_DATA_W-1:0]   wdata,
    output logic [AXI_DATA_W/8-1:0] wstrb,
    output logic                    wlast,
    // AXI B
    input  logic                    bvalid,
    input  logic [1:0]              bresp,
    output logic                    bready,
    // data FIFO
    output logic                    fifo_wr,
    output logic [AXI_DATA_W-1:0]   fifo_wdata,
    input  logic                    fifo_full,
    output logic                    fifo_rd,
    input  logic [AXI_DATA_W-1:0]   fifo_rdata,
    input  logic                    fifo_empty,
    // control
    input  logic                    dma_active_i,
    input  logic                    dma_abort_i,
    input  logic                    clear_i,
    // status
    output logic                    pend_o,
    output logic                    err_valid_o,
    output logic                    err_src_o,
    output logic [1:0]              err_resp_o,
    output logic [AXI_ADDR_W-1:0]   err_addr_o,
    output logic [7:0]              err_cnt_o
);

    localparam int unsigned STRB_W = AXI_DATA_W / 8;
    localparam int unsigned RD_PW  = (RD_OUTS > 1) ? $clog2(RD_OUTS) : 1;
    localparam int unsigned WR_PW  = (WR_OUTS > 1) ? $clog2(WR_OUTS) : 1;
    localparam logic [RD_PW-1:0] RD_PTR_MAX = RD_PW'(RD_OUTS - 1);
    localparam logic [WR_PW-1:0] WR_PTR_MAX = WR_PW'(WR_OUTS - 1);
    localparam logic [4:0] RD_MAX = 5'(RD_OUTS);
    localparam logic [4:0] WR_MAX = 5'(WR_OUTS);

    // Byte enables for one beat of a burst: first/last beats use the edge masks.
    function automatic logic [STRB_W-1:0] beat_strb(input logic [7:0] beat,
                                                     input logic [7:0] len,
                                                     input logic [STRB_W-1:0] fstrb,
                                                     input logic [STRB_W-1:0] lstrb);
        if (len == 8'd0)       return fstrb & lstrb;
        else if (beat == 8'd0) return fstrb;
        else if (beat == len)  return lstrb;
        else                   return '1;
    endfunction

    function automatic logic [AXI_DATA_W-1:0] byte_mask(input logic [STRB_W-1:0] strb);
        logic [AXI_DATA_W-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < STRB_W; i++) m[8*i +: 8] = {8{strb[i]}};
        return m;
    endfunction

    // Read context queue
    logic [STRB_W-1:0]     rq_fstrb [RD_OUTS];
    logic [STRB_W-1:0]     rq_lstrb [RD_OUTS];
    logic [7:0]            rq_len   [RD_OUTS];
    logic [AXI_ADDR_W-1:0] rq_addr  [RD_OUTS];
    logic [RD_PW-1:0]      rq_wptr_q, rq_rptr_q;
    logic [4:0]            rd_cnt_q;
    logic [7:0]            r_beat_q;

    // W/B context queue; W head and B head advance independently
    logic [STRB_W-1:0]     wq_fstrb [WR_OUTS];
    logic [STRB_W-1:0]     wq_lstrb [WR_OUTS];
    logic [7:0]            wq_len   [WR_OUTS];
    logic [AXI_ADDR_W-1:0] wq_addr  [WR_OUTS];
    logic [WR_PW-1:0]      wq_wptr_q, wq_hptr_q, wq_bptr_q;
    logic [4:0]            wr_cnt_q, w_pend_q;
    logic [7:0]            w_beat_q;

    // Sticky AW holding registers
    logic                  aw_hold_q;
    logic [AXI_ADDR_W-1:0] aw_addr_q;
    logic [7:0]            aw_len_q;
    logic [2:0]            aw_size_q;
    logic                  aw_incr_q;
    logic [STRB_W-1:0]     aw_fstrb_q, aw_lstrb_q;

    logic                  err_valid_q, err_src_q;
    logic [1:0]            err_resp_q;
    logic [AXI_ADDR_W-1:0] err_addr_q;
    logic [7:0]            err_cnt_q;

    logic active, ar_hs, r_hs, r_done, rd_pop;
    logic aw_req, aw_hs, w_hs, w_done, b_hs, b_pop, rd_err, wr_err;
    logic [AXI_ADDR_W-1:0] aw_addr_sel;
    logic [7:0]            aw_len_sel;
    logic [2:0]            aw_size_sel;
    logic                  aw_incr_sel;
    logic [STRB_W-1:0]     aw_fstrb_sel, aw_lstrb_sel, r_strb, w_strb;
    logic [8:0]            err_sum;

    // Reset also forces every handshake output low.
    assign active = dma_active_i & ~rst;

    // ---------------- read path ----------------
    assign arvalid      = active & rd_req_valid & (rd_cnt_q < RD_MAX);
    assign ar_hs        = arvalid & arready;
    assign rd_req_ready = ar_hs;
    assign araddr       = arvalid ? rd_req_addr : '0;
    assign arlen        = arvalid ? rd_req_len : 8'd0;
    assign arsize       = arvalid ? rd_req_size : 3'd0;
    assign arburst      = {1'b0, arvalid & rd_req_incr};
    assign arid         = AXI_ID_W'(DMA_ID);
    assign arprot       = 3'b010;

    assign rready  = active & (~fifo_full | dma_abort_i);
    assign r_hs    = rvalid & rready;
    assign r_done  = r_hs & rlast;
    assign rd_pop  = r_done & (rd_cnt_q != 5'd0);
    assign r_strb  = beat_strb(r_beat_q, rq_len[rq_rptr_q], rq_fstrb[rq_rptr_q],
                               rq_lstrb[rq_rptr_q]);
    assign fifo_wr    = r_hs & ~dma_abort_i;
    assign fifo_wdata = r_hs ? (rdata & byte_mask(r_strb)) : '0;

    // ---------------- write path ----------------
    assign aw_req       = active & wr_req_valid & (wr_cnt_q < WR_MAX) &
                          (~fifo_empty | dma_abort_i);
    assign awvalid      = active & (aw_hold_q | aw_req);
    assign aw_hs        = awvalid & awready;
    assign wr_req_ready = aw_hs;
    assign aw_addr_sel  = aw_hold_q ? aw_addr_q  : wr_req_addr;
    assign aw_len_sel   = aw_hold_q ? aw_len_q   : wr_req_len;
    assign aw_size_sel  = aw_hold_q ? aw_size_q  : wr_req_size;
    assign aw_incr_sel  = aw_hold_q ? aw_incr_q  : wr_req_incr;
    assign aw_fstrb_sel = aw_hold_q ? aw_fstrb_q : wr_req_fstrb;
    assign aw_lstrb_sel = aw_hold_q ? aw_lstrb_q : wr_req_lstrb;
    assign awaddr       = awvalid ? aw_addr_sel : '0;
    assign awlen        = awvalid ? aw_len_sel : 8'd0;
    assign awsize       = awvalid ? aw_size_sel : 3'd0;
    assign awburst      = {1'b0, awvalid & aw_incr_sel};
    assign awid         = AXI_ID_W'(DMA_ID);
    assign awprot       = 3'b010;

    // W only runs for bursts whose AW has already been accepted.
    assign wvalid  = active & (w_pend_q != 5'd0) & (~fifo_empty | dma_abort_i);
    assign w_hs    = wvalid & wready;
    assign wlast   = wvalid & (w_beat_q == wq_len[wq_hptr_q]);
    assign w_done  = w_hs & wlast;
    assign w_strb  = beat_strb(w_beat_q, wq_len[wq_hptr_q], wq_fstrb[wq_hptr_q],
                               wq_lstrb[wq_hptr_q]);
    assign wstrb   = (wvalid & ~dma_abort_i) ? w_strb : '0;
    assign wdata   = wvalid ? fifo_rdata : '0;
    assign fifo_rd = w_hs & ~dma_abort_i;

    assign bready = active;
    assign b_hs   = bvalid & bready;
    assign b_pop  = b_hs & (wr_cnt_q != 5'd0);

    // ---------------- status ----------------
    assign rd_err  = r_done & ((rresp == 2'b10) | (rresp == 2'b11));
    assign wr_err  = b_hs & ((bresp == 2'b10) | (bresp == 2'b11));
    assign err_sum = {1'b0, err_cnt_q} + {8'd0, rd_err} + {8'd0, wr_err};

    assign pend_o      = (rd_cnt_q != 5'd0) | (wr_cnt_q != 5'd0);
    assign err_valid_o = err_valid_q;
    assign err_src_o   = err_src_q;
    assign err_resp_o  = err_resp_q;
    assign err_addr_o  = err_addr_q;
    assign err_cnt_o   = err_cnt_q;

    // Queue storage; occupancy is tracked by the pointers, so no reset needed.
    always_ff @(posedge clk) begin
        if (ar_hs) begin
            rq_fstrb[rq_wptr_q] <= rd_req_fstrb;
            rq_lstrb[rq_wptr_q] <= rd_req_lstrb;
            rq_len[rq_wptr_q]   <= rd_req_len;
            rq_addr[rq_wptr_q]  <= rd_req_addr;
        end
        if (aw_hs) begin
            wq_fstrb[wq_wptr_q] <= aw_fstrb_sel;
            wq_lstrb[wq_wptr_q] <= aw_lstrb_sel;
            wq_len[wq_wptr_q]   <= aw_len_sel;
            wq_addr[wq_wptr_q]  <= aw_addr_sel;
        end
    end

    // Burst bookkeeping: counters, pointers, beat counters and sticky AW.
    always_ff @(posedge clk) begin
        if (rst || !dma_active_i) begin
            rq_wptr_q  <= '0;
            rq_rptr_q  <= '0;
            rd_cnt_q   <= '0;
            r_beat_q   <= '0;
            wq_wptr_q  <= '0;
            wq_hptr_q  <= '0;
            wq_bptr_q  <= '0;
            wr_cnt_q   <= '0;
            w_pend_q   <= '0;
            w_beat_q   <= '0;
            aw_hold_q  <= 1'b0;
            aw_addr_q  <= '0;
            aw_len_q   <= '0;
            aw_size_q  <= '0;
            aw_incr_q  <= 1'b0;
            aw_fstrb_q <= '0;
            aw_lstrb_q <= '0;
        end else begin
            if (ar_hs)  rq_wptr_q <= (rq_wptr_q == RD_PTR_MAX) ? '0 : rq_wptr_q + 1'b1;
            if (rd_pop) rq_rptr_q <= (rq_rptr_q == RD_PTR_MAX) ? '0 : rq_rptr_q + 1'b1;
            if (ar_hs != rd_pop) rd_cnt_q <= ar_hs ? rd_cnt_q + 5'd1 : rd_cnt_q - 5'd1;
            if (r_done)    r_beat_q <= '0;
            else if (r_hs) r_beat_q <= r_beat_q + 8'd1;

            aw_hold_q <= awvalid & ~awready;
            if (awvalid && !aw_hold_q) begin
                aw_addr_q  <= wr_req_addr;
                aw_len_q   <= wr_req_len;
                aw_size_q  <= wr_req_size;
                aw_incr_q  <= wr_req_incr;
                aw_fstrb_q <= wr_req_fstrb;
                aw_lstrb_q <= wr_req_lstrb;
            end

            if (aw_hs)  wq_wptr_q <= (wq_wptr_q == WR_PTR_MAX) ? '0 : wq_wptr_q + 1'b1;
            if (w_done) wq_hptr_q <= (wq_hptr_q == WR_PTR_MAX) ? '0 : wq_hptr_q + 1'b1;
            if (b_pop)  wq_bptr_q <= (wq_bptr_q == WR_PTR_MAX) ? '0 : wq_bptr_q + 1'b1;
            if (aw_hs != w_done) w_pend_q <= aw_hs ? w_pend_q + 5'd1 : w_pend_q - 5'd1;
            if (aw_hs != b_pop)  wr_cnt_q <= aw_hs ? wr_cnt_q + 5'd1 : wr_cnt_q - 5'd1;
            if (w_done)    w_beat_q <= '0;
            else if (w_hs) w_beat_q <= w_beat_q + 8'd1;
        end
    end

    // Error capture: first error sticks, read beats write on a tie, clear wins.
    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            err_valid_q <= 1'b0;
            err_src_q   <= 1'b0;
            err_resp_q  <= '0;
            err_addr_q  <= '0;
            err_cnt_q   <= '0;
        end else begin
            if (!err_valid_q && (rd_err || wr_err)) begin
                err_valid_q <= 1'b1;
                err_src_q   <= ~rd_err;
                err_resp_q  <= rd_err ? rresp : bresp;
                err_addr_q  <= rd_err ? rq_addr[rq_rptr_q] : wq_addr[wq_bptr_q];
            end
            if (rd_err || wr_err) err_cnt_q <= err_sum[8] ? 8'hFF : err_sum[7:0];
        end
    end

endmodule

// File: tb/tb_dma_axi_mif.sv
// Scoreboard bench for dma_axi_mif: stimulus pushes expected AR/AW/W/FIFO
// traffic into queues, a monitor pops and compares on each DUT handshake.
module tb_dma_axi_mif;

    logic        clk, rst;
    logic        rd_req_valid, rd_req_ready, rd_req_incr;
    logic [31:0] rd_req_addr;
    logic [7:0]  rd_req_len, rd_req_fstrb, rd_req_lstrb;
    logic [2:0]  rd_req_size;
    logic        wr_req_valid, wr_req_ready, wr_req_incr;
    logic [31:0] wr_req_addr;
    logic [7:0]  wr_req_len, wr_req_fstrb, wr_req_lstrb;
    logic [2:0]  wr_req_size;
    logic        arvalid, arready;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize, arprot;
    logic [1:0]  arburst;
    logic [3:0]  arid;
    logic        rvalid, rlast, rready;
    logic [63:0] rdata;
    logic [1:0]  rresp;
    logic        awvalid, awready;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize, awprot;
    logic [1:0]  awburst;
    logic [3:0]  awid;
    logic        wvalid, wready, wlast;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic        bvalid, bready;
    logic [1:0]  bresp;
    logic        fifo_wr, fifo_full, fifo_rd, fifo_empty;
    logic [63:0] fifo_wdata, fifo_rdata;
    logic        dma_active_i, dma_abort_i, clear_i;
    logic        pend_o, err_valid_o, err_src_o;
    logic [1:0]  err_resp_o;
    logic [31:0] err_addr_o;
    logic [7:0]  err_cnt_o;

    int checks = 0;
    int errors = 0;
    int ar_hs_cnt = 0;
    int aw_hs_cnt = 0;
    int w_hs_cnt = 0;
    int base;

    logic [127:0] exp_ar[$];
    logic [127:0] exp_aw[$];
    logic [127:0] exp_w[$];
    logic [127:0] exp_fifo[$];

    dma_axi_mif dut (
        .clk(clk), .rst(rst),
        .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready),
        .rd_req_addr(rd_req_addr), .rd_req_len(rd_req_len), .rd_req_size(rd_req_size),
        .rd_req_incr(rd_req_incr), .rd_req_fstrb(rd_req_fstrb), .rd_req_lstrb(rd_req_lstrb),
        .wr_req_valid(wr_req_valid), .wr_req_ready(wr_req_ready),
        .wr_req_addr(wr_req_addr), .wr_req_len(wr_req_len), .wr_req_size(wr_req_size),
        .wr_req_incr(wr_req_incr), .wr_req_fstrb(wr_req_fstrb), .wr_req_lstrb(wr_req_lstrb),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen),
        .arsize(arsize), .arburst(arburst), .arid(arid), .arprot(arprot),
        .rvalid(rvalid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rready(rready),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen),
        .awsize(awsize), .awburst(awburst), .awid(awid), .awprot(awprot),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .bvalid(bvalid), .bresp(bresp), .bready(bready),
        .fifo_wr(fifo_wr), .fifo_wdata(fifo_wdata), .fifo_full(fifo_full),
        .fifo_rd(fifo_rd), .fifo_rdata(fifo_rdata), .fifo_empty(fifo_empty),
        .dma_active_i(dma_active_i), .dma_abort_i(dma_abort_i), .clear_i(clear_i),
        .pend_o(pend_o), .err_valid_o(err_valid_o), .err_src_o(err_src_o),
        .err_resp_o(err_resp_o), .err_addr_o(err_addr_o), .err_cnt_o(err_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_evt(input string name, input string got, input string want);
        checks++;
        errors++;
        $display("FAIL %s: got %s expected %s", name, got, want);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected AR/AW fields: {id, prot, burst, size, len, addr}
    function automatic logic [127:0] a_pack(input logic [31:0] addr, input logic [7:0] len,
                                            input logic [2:0] size, input logic incr);
        return 128'({4'h0, 3'b010, (incr ? 2'b01 : 2'b00), size, len, addr});
    endfunction

    function automatic logic [127:0] w_pack(input logic [63:0] d, input logic [7:0] s,
                                            input logic l, input logic rd);
        return 128'({d, s, l, rd});
    endfunction

    task automatic set_rd(input logic [31:0] addr, input logic [7:0] len,
                          input logic [7:0] f, input logic [7:0] l);
        rd_req_addr = addr; rd_req_len = len; rd_req_size = 3'd3; rd_req_incr = 1'b1;
        rd_req_fstrb = f; rd_req_lstrb = l; rd_req_valid = 1'b1;
    endtask

    task automatic set_wr(input logic [31:0] addr, input logic [7:0] len,
                          input logic [7:0] f, input logic [7:0] l);
        wr_req_addr = addr; wr_req_len = len; wr_req_size = 3'd3; wr_req_incr = 1'b1;
        wr_req_fstrb = f; wr_req_lstrb = l; wr_req_valid = 1'b1;
    endtask

    // Wait (bounded) for the read request handshake, then drop the request.
    task automatic wait_rd_hs();
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (rd_req_ready) seen = 1'b1;
        end
        if (!seen) fail_evt("rd_req_hs", "no handshake", "handshake");
        @(posedge clk);
        #1;
        rd_req_valid = 1'b0;
    endtask

    // Monitor: compares every DUT transfer against the scoreboard queues.
    initial begin
        forever begin
            @(negedge clk);
            if (arvalid && arready) begin
                ar_hs_cnt++;
                if (exp_ar.size() == 0) fail_evt("ar_unexpected", "AR handshake", "none");
                else check("ar_fields", 128'({arid, arprot, arburst, arsize, arlen, araddr}),
                           exp_ar.pop_front());
            end
            if (awvalid && awready) begin
                aw_hs_cnt++;
                if (exp_aw.size() == 0) fail_evt("aw_unexpected", "AW handshake", "none");
                else check("aw_fields", 128'({awid, awprot, awburst, awsize, awlen, awaddr}),
                           exp_aw.pop_front());
            end
            if (wvalid && wready) begin
                w_hs_cnt++;
                if (exp_w.size() == 0) fail_evt("w_unexpected", "W beat", "none");
                else check("w_beat", w_pack(wdata, wstrb, wlast, fifo_rd), exp_w.pop_front());
            end
            if (fifo_wr) begin
                if (exp_fifo.size() == 0) fail_evt("fifo_unexpected", "fifo_wr", "none");
                else check("fifo_wdata", 128'(fifo_wdata), exp_fifo.pop_front());
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "simulation timed out");
    end

    initial begin
        rst = 1'b1; dma_active_i = 1'b1; dma_abort_i = 1'b0; clear_i = 1'b0;
        rd_req_valid = 1'b0; rd_req_addr = '0; rd_req_len = '0; rd_req_size = '0;
        rd_req_incr = 1'b0; rd_req_fstrb = '0; rd_req_lstrb = '0;
        wr_req_valid = 1'b0; wr_req_addr = '0; wr_req_len = '0; wr_req_size = '0;
        wr_req_incr = 1'b0; wr_req_fstrb = '0; wr_req_lstrb = '0;
        arready = 1'b0; awready = 1'b0; wready = 1'b0;
        rvalid = 1'b0; rdata = '0; rresp = '0; rlast = 1'b0;
        bvalid = 1'b0; bresp = '0;
        fifo_full = 1'b0; fifo_empty = 1'b1; fifo_rdata = '0;

        // reset state
        repeat (2) tick();
        @(negedge clk);
        check("rst_arvalid", 128'(arvalid), 128'(0));
        check("rst_awvalid", 128'(awvalid), 128'(0));
        check("rst_rready", 128'(rready), 128'(0));
        check("rst_wvalid", 128'(wvalid), 128'(0));
        check("rst_bready", 128'(bready), 128'(0));
        check("rst_fifo_wr", 128'(fifo_wr), 128'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_pend", 128'(pend_o), 128'(0));
        check("rst_err_valid", 128'(err_valid_o), 128'(0));
        check("rst_err_cnt", 128'(err_cnt_o), 128'(0));

        // read len=3 with edge masks
        arready = 1'b1;
        exp_ar.push_back(a_pack(32'h1000, 8'd3, 3'd3, 1'b1));
        set_rd(32'h1000, 8'd3, 8'hF0, 8'h0F);
        wait_rd_hs();
        exp_fifo.push_back(128'(64'hFFFF_FFFF_0000_0000));
        exp_fifo.push_back(128'(64'hFFFF_FFFF_FFFF_FFFF));
        exp_fifo.push_back(128'(64'hFFFF_FFFF_FFFF_FFFF));
        exp_fifo.push_back(128'(64'h0000_0000_FFFF_FFFF));
        for (int b = 0; b < 4; b++) begin
            rvalid = 1'b1; rdata = '1; rresp = 2'b00; rlast = (b == 3);
            tick();
        end
        rvalid = 1'b0; rlast = 1'b0;
        check("rd_drain_pend", 128'(pend_o), 128'(0));

        // five back-to-back reads against four outstanding slots
        base = ar_hs_cnt;
        for (int i = 0; i < 5; i++) exp_ar.push_back(a_pack(32'h2000, 8'd0, 3'd3, 1'b1));
        set_rd(32'h2000, 8'd0, 8'hFF, 8'hFF);
        repeat (8) tick();
        check("ar_limit_cnt", 128'(ar_hs_cnt - base), 128'(4));
        check("ar_limit_valid", 128'(arvalid), 128'(0));
        exp_fifo.push_back(128'(64'h1122_3344_5566_7788));
        rvalid = 1'b1; rlast = 1'b1; rdata = 64'h1122_3344_5566_7788;
        @(negedge clk);
        check("ar_blocked_rlast", 128'(arvalid), 128'(0));
        @(posedge clk);
        #1;
        rvalid = 1'b0; rlast = 1'b0;
        @(negedge clk);
        check("ar_resume", 128'(arvalid), 128'(1));
        @(posedge clk);
        #1;
        rd_req_valid = 1'b0;
        check("ar_total_cnt", 128'(ar_hs_cnt - base), 128'(5));
        for (int i = 0; i < 4; i++) begin
            exp_fifo.push_back(128'({32'hA0A0_0000 + i, 32'h0B0B_0B0B}));
            rvalid = 1'b1; rlast = 1'b1; rdata = {32'hA0A0_0000 + i, 32'h0B0B_0B0B};
            tick();
        end
        rvalid = 1'b0; rlast = 1'b0; arready = 1'b0;
        check("rd4_drain_pend", 128'(pend_o), 128'(0));

        // sticky AW while fifo_empty toggles
        base = aw_hs_cnt;
        fifo_empty = 1'b0;
        exp_aw.push_back(a_pack(32'h3000, 8'd0, 3'd3, 1'b1));
        set_wr(32'h3000, 8'd0, 8'h3C, 8'hFF);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("aw_sticky_valid", 128'(awvalid), 128'(1));
            check("aw_sticky_addr", 128'(awaddr), 128'(32'h3000));
            @(posedge clk);
            #1;
            fifo_empty = ~fifo_empty;
        end
        awready = 1'b1;
        tick();
        wr_req_valid = 1'b0; awready = 1'b0;
        check("aw_once", 128'(aw_hs_cnt - base), 128'(1));
        fifo_empty = 1'b0; wready = 1'b1; fifo_rdata = 64'hAABB_CCDD_EEFF_0011;
        exp_w.push_back(w_pack(64'hAABB_CCDD_EEFF_0011, 8'h3C, 1'b1, 1'b1));
        tick();
        wready = 1'b0; fifo_empty = 1'b1;
        bvalid = 1'b1; bresp = 2'b00;
        tick();
        bvalid = 1'b0;
        check("wr_pend", 128'(pend_o), 128'(0));

        // write len=1 under abort: no strobes, no FIFO reads
        base = w_hs_cnt;
        dma_abort_i = 1'b1; fifo_empty = 1'b1; awready = 1'b1; wready = 1'b1;
        fifo_rdata = 64'h5555_6666_7777_8888;
        exp_aw.push_back(a_pack(32'h4000, 8'd1, 3'd3, 1'b1));
        exp_w.push_back(w_pack(64'h5555_6666_7777_8888, 8'h00, 1'b0, 1'b0));
        exp_w.push_back(w_pack(64'h5555_6666_7777_8888, 8'h00, 1'b1, 1'b0));
        set_wr(32'h4000, 8'd1, 8'hFF, 8'hFF);
        tick();
        wr_req_valid = 1'b0;
        repeat (4) tick();
        check("abort_w_beats", 128'(w_hs_cnt - base), 128'(2));
        awready = 1'b0; wready = 1'b0;
        bvalid = 1'b1;
        tick();
        bvalid = 1'b0; dma_abort_i = 1'b0;
        check("abort_pend", 128'(pend_o), 128'(0));

        // same-cycle read DECERR and write SLVERR
        arready = 1'b1;
        exp_ar.push_back(a_pack(32'h5000, 8'd0, 3'd3, 1'b1));
        set_rd(32'h5000, 8'd0, 8'hFF, 8'hFF);
        wait_rd_hs();
        arready = 1'b0;
        fifo_empty = 1'b0; awready = 1'b1; wready = 1'b1; fifo_rdata = 64'h0102_0304_0506_0708;
        exp_aw.push_back(a_pack(32'h6000, 8'd0, 3'd3, 1'b1));
        exp_w.push_back(w_pack(64'h0102_0304_0506_0708, 8'hFF, 1'b1, 1'b1));
        set_wr(32'h6000, 8'd0, 8'hFF, 8'hFF);
        tick();
        wr_req_valid = 1'b0; awready = 1'b0;
        tick();
        wready = 1'b0; fifo_empty = 1'b1;
        exp_fifo.push_back(128'(64'hDEAD_BEEF_0123_4567));
        rvalid = 1'b1; rlast = 1'b1; rresp = 2'b11; rdata = 64'hDEAD_BEEF_0123_4567;
        bvalid = 1'b1; bresp = 2'b10;
        tick();
        rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00; bvalid = 1'b0; bresp = 2'b00;
        check("err_valid", 128'(err_valid_o), 128'(1));
        check("err_src", 128'(err_src_o), 128'(0));
        check("err_resp", 128'(err_resp_o), 128'(2'b11));
        check("err_addr", 128'(err_addr_o), 128'(32'h5000));
        check("err_cnt", 128'(err_cnt_o), 128'(2));
        check("err_pend", 128'(pend_o), 128'(0));
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        check("clr_valid", 128'(err_valid_o), 128'(0));
        check("clr_src", 128'(err_src_o), 128'(0));
        check("clr_resp", 128'(err_resp_o), 128'(0));
        check("clr_addr", 128'(err_addr_o), 128'(0));
        check("clr_cnt", 128'(err_cnt_o), 128'(0));

        // inactive: no handshakes even with requests pending
        dma_active_i = 1'b0; fifo_empty = 1'b0; arready = 1'b1; awready = 1'b1;
        set_rd(32'h7000, 8'd0, 8'hFF, 8'hFF);
        set_wr(32'h8000, 8'd0, 8'hFF, 8'hFF);
        @(negedge clk);
        check("idle_arvalid", 128'(arvalid), 128'(0));
        check("idle_awvalid", 128'(awvalid), 128'(0));
        check("idle_rready", 128'(rready), 128'(0));
        check("idle_bready", 128'(bready), 128'(0));
        @(posedge clk);
        #1;
        rd_req_valid = 1'b0; wr_req_valid = 1'b0; arready = 1'b0; awready = 1'b0;
        fifo_empty = 1'b1; dma_active_i = 1'b1;

        repeat (3) tick();
        check("left_ar", 128'(exp_ar.size()), 128'(0));
        check("left_aw", 128'(exp_aw.size()), 128'(0));
        check("left_w", 128'(exp_w.size()), 128'(0));
        check("left_fifo", 128'(exp_fifo.size()), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
